// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command-frame slave and its RAM.
package spi_pkg;
  localparam int MEM_DEPTH = 256;
  localparam int ADDR_SIZE = 8;
  localparam int DIN_W     = 10;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;
endpackage

// File: rtl/spi_if.sv
// Serial pins between the external SPI controller and the slave block.
interface spi_if;
  logic MOSI;
  logic SS_n;
  logic MISO;

  modport master (output MOSI, output SS_n, input MISO);
  modport slave  (input MOSI, input SS_n, output MISO);
endinterface

// File: rtl/spi_ram.sv
// Command-driven RAM: a completed 10-bit frame sets an address, writes or reads a word.
module spi_ram
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = spi_pkg::MEM_DEPTH,
  parameter int ADDR_SIZE = spi_pkg::ADDR_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIN_W-1:0] din,
  input  logic             rx_valid,
  output logic [7:0]       dout,
  output logic             tx_valid
);
  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [7:0]           tx_dout;

  assign dout = tx_dout;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && rx_valid && din[9:8] == OP_WR_DATA) mem[wr_addr] <= din[7:0];
  end

  // tx_valid is a one-cycle strobe; the master holds its own read-out state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      tx_dout  <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (rx_valid) begin
        case (din[9:8])
          OP_WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0];
          OP_RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0];
          OP_RD_DATA: begin
            tx_dout  <= mem[rd_addr];
            tx_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: rtl/spi_master.sv
// SPI slave-side frame decoder: FSM, 10-bit serial shifter and MISO serializer around spi_ram.
module spi_master
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = spi_pkg::MEM_DEPTH,
  parameter int ADDR_SIZE = spi_pkg::ADDR_SIZE
) (
  input  logic clk,
  input  logic rst,
  spi_if.slave bus
);
  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [DIN_W-1:0] din_q, din_d;
  logic             rx_valid_q, rx_valid_d;
  logic             miso_q, miso_d;
  logic             rd_addr_received_q, rd_addr_received_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic [3:0]       tx_cnt_q, tx_cnt_d;
  logic [7:0]       dout;
  logic             tx_valid;

  assign bus.MISO = miso_q;

  spi_ram #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) m1 (
    .clk      (clk),
    .rst      (rst),
    .din      (din_q),
    .rx_valid (rx_valid_q),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      din_q              <= '0;
      rx_valid_q         <= 1'b0;
      miso_q             <= 1'b0;
      rd_addr_received_q <= 1'b0;
      tx_sh_q            <= '0;
      tx_cnt_q           <= '0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      din_q              <= din_d;
      rx_valid_q         <= rx_valid_d;
      miso_q             <= miso_d;
      rd_addr_received_q <= rd_addr_received_d;
      tx_sh_q            <= tx_sh_d;
      tx_cnt_q           <= tx_cnt_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    din_d              = din_q;
    rx_valid_d         = 1'b0;
    miso_d             = 1'b0;
    rd_addr_received_d = rd_addr_received_q;
    tx_sh_d            = tx_sh_q;
    tx_cnt_d           = tx_cnt_q;

    // The address flag follows the RAM action, whatever state decoded the frame.
    if (rx_valid_q) begin
      if (din_q[9:8] == OP_RD_ADDR) rd_addr_received_d = 1'b1;
      if (din_q[9:8] == OP_RD_DATA) rd_addr_received_d = 1'b0;
    end

    if (bus.SS_n) begin
      state_d  = IDLE;
      cnt_d    = '0;
      tx_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CHK_CMD;
          cnt_d   = '0;
        end
        CHK_CMD: begin
          cnt_d = '0;
          if (!bus.MOSI)               state_d = WRITE;
          else if (rd_addr_received_q) state_d = READ_DATA;
          else                         state_d = READ_ADD;
        end
        default: begin
          // Counter saturates at 10 so trailing bits are dropped until SS_n rises.
          if (cnt_q < 4'd10) begin
            din_d = {din_q[DIN_W-2:0], bus.MOSI};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9) rx_valid_d = 1'b1;
          end
        end
      endcase

      if (tx_valid && state_q == READ_DATA) begin
        miso_d   = dout[7];
        tx_sh_d  = {dout[6:0], 1'b0};
        tx_cnt_d = 4'd7;
      end else if (tx_cnt_q != 4'd0) begin
        miso_d   = tx_sh_q[7];
        tx_sh_d  = {tx_sh_q[6:0], 1'b0};
        tx_cnt_d = tx_cnt_q - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed frames plus randomized write/read traffic vs. a RAM model.
module tb_spi_master;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchecks = 0;
  int   nerr    = 0;

  logic [7:0] m_mem [256];
  logic       m_written [256];
  logic [7:0] m_wr, m_rd;
  logic       m_rcv;

  spi_if bus ();

  spi_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model of the RAM side effects of one completed frame.
  task automatic model_act(input logic [9:0] d);
    case (d[9:8])
      2'b00: m_wr = d[7:0];
      2'b01: begin m_mem[m_wr] = d[7:0]; m_written[m_wr] = 1'b1; end
      2'b10: begin m_rd = d[7:0]; m_rcv = 1'b1; end
      default: m_rcv = 1'b0;
    endcase
  endtask

  // Idle cycle, command bit, then nbits of payload MSB-first; leaves SS_n low.
  task automatic frame(input logic cmd, input logic [9:0] bits, input int nbits);
    @(negedge clk); bus.SS_n = 1'b0; bus.MOSI = 1'($urandom);
    @(negedge clk); bus.MOSI = cmd;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); bus.MOSI = bits[9-i];
    end
  endtask

  task automatic close();
    @(negedge clk); bus.SS_n = 1'b1; bus.MOSI = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr_frame(input logic cmd, input logic [9:0] d);
    frame(cmd, d, 10);
    repeat (2) @(posedge clk);
    #1;
    model_act(d);
    close();
  endtask

  task automatic rd_frame(input string name, input logic [7:0] exp);
    logic [7:0] got;
    logic [9:0] d;
    d = {2'b11, 8'($urandom)};
    frame(1'b1, d, 10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (bus.MISO !== 1'b0) begin nerr++; $display("FAIL %s_early MISO=%b exp=0", name, bus.MISO); end
    nchecks++;
    for (int i = 7; i >= 0; i--) begin
      @(posedge clk); #1;
      got[i] = bus.MISO;
    end
    model_act(d);
    if (got !== exp) begin nerr++; $display("FAIL %s_byte got=%h exp=%h", name, got, exp); end
    nchecks++;
    @(posedge clk); #1;
    if (bus.MISO !== 1'b0) begin nerr++; $display("FAIL %s_tail MISO=%b exp=0", name, bus.MISO); end
    nchecks++;
    if (dut.rd_addr_received_q !== m_rcv) begin
      nerr++; $display("FAIL %s_rcv got=%b exp=%b", name, dut.rd_addr_received_q, m_rcv);
    end
    nchecks++;
    close();
  endtask

  task automatic test_reset();
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_wr = 8'h00; m_rd = 8'h00; m_rcv = 1'b0;
    if (bus.MISO !== 1'b0) begin nerr++; $display("FAIL reset_miso got=%b exp=0", bus.MISO); end
    nchecks++;
    if (dut.state_q !== IDLE) begin nerr++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
    nchecks++;
    if (dut.rd_addr_received_q !== 1'b0) begin nerr++; $display("FAIL reset_rcv got=%b exp=0", dut.rd_addr_received_q); end
    nchecks++;
    if (dut.m1.wr_addr !== 8'h00) begin nerr++; $display("FAIL reset_wr_addr got=%h exp=00", dut.m1.wr_addr); end
    nchecks++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_wr_addr();
    frame(1'b0, {2'b00, 8'hFF}, 10);
    @(posedge clk); #1;
    if (dut.rx_valid_q !== 1'b1) begin nerr++; $display("FAIL wr_addr_rxv_hi got=%b exp=1", dut.rx_valid_q); end
    nchecks++;
    @(posedge clk); #1;
    if (dut.rx_valid_q !== 1'b0) begin nerr++; $display("FAIL wr_addr_rxv_lo got=%b exp=0", dut.rx_valid_q); end
    nchecks++;
    model_act({2'b00, 8'hFF});
    if (dut.m1.wr_addr !== m_wr) begin nerr++; $display("FAIL wr_addr got=%h exp=%h", dut.m1.wr_addr, m_wr); end
    nchecks++;
    // Trailing bits after the tenth must not produce a second pulse.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.MOSI = 1'b1;
      @(posedge clk); #1;
      if (dut.rx_valid_q !== 1'b0) begin nerr++; $display("FAIL wr_addr_extra got=%b exp=0", dut.rx_valid_q); end
      nchecks++;
    end
    close();
  endtask

  task automatic test_wr_data();
    wr_frame(1'b0, {2'b01, 8'hFF});
    if (dut.m1.mem[8'hFF] !== 8'hFF) begin nerr++; $display("FAIL wr_data got=%h exp=ff", dut.m1.mem[8'hFF]); end
    nchecks++;
  endtask

  task automatic test_rd_addr();
    wr_frame(1'b1, {2'b10, 8'hFF});
    if (dut.m1.rd_addr !== m_rd) begin nerr++; $display("FAIL rd_addr got=%h exp=%h", dut.m1.rd_addr, m_rd); end
    nchecks++;
    if (dut.rd_addr_received_q !== 1'b1) begin nerr++; $display("FAIL rd_addr_rcv got=%b exp=1", dut.rd_addr_received_q); end
    nchecks++;
  endtask

  task automatic test_rd_data();
    rd_frame("rd_ff", 8'hFF);
    wr_frame(1'b0, {2'b00, 8'h3C});
    wr_frame(1'b0, {2'b01, 8'hA5});
    wr_frame(1'b1, {2'b10, 8'h3C});
    rd_frame("rd_a5", 8'hA5);
  endtask

  task automatic test_abort();
    frame(1'b0, {2'b01, 8'h00}, 7);
    close();
    if (dut.m1.mem[8'h3C] !== 8'hA5) begin nerr++; $display("FAIL abort_mem got=%h exp=a5", dut.m1.mem[8'h3C]); end
    nchecks++;
    if (dut.state_q !== IDLE) begin nerr++; $display("FAIL abort_state got=%0d exp=%0d", dut.state_q, IDLE); end
    nchecks++;
    // Opcode decoded from a WRITE-state frame still sets the read address.
    wr_frame(1'b0, {2'b10, 8'h3C});
    if (dut.rd_addr_received_q !== 1'b1) begin nerr++; $display("FAIL mismatch_rcv got=%b exp=1", dut.rd_addr_received_q); end
    nchecks++;
    rd_frame("abort_rd", 8'hA5);
  endtask

  task automatic test_random();
    logic [7:0] a, d;
    logic [7:0] ra;
    for (int it = 0; it < 20; it++) begin
      a = 8'($urandom); d = 8'($urandom);
      wr_frame(1'b0, {2'b00, a});
      wr_frame(1'b0, {2'b01, d});
      if ($urandom_range(0, 1) == 1) begin
        frame(1'($urandom), 10'($urandom), $urandom_range(0, 9));
        close();
      end
      do ra = 8'($urandom); while (!m_written[ra]);
      wr_frame(1'b1, {2'b10, ra});
      rd_frame($sformatf("rand%0d", it), m_mem[ra]);
    end
  endtask

  task automatic test_rst_mid();
    frame(1'b0, {2'b00, 8'h5A}, 4);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    m_wr = 8'h00; m_rd = 8'h00; m_rcv = 1'b0;
    if (dut.state_q !== IDLE) begin nerr++; $display("FAIL rst_mid_state got=%0d exp=%0d", dut.state_q, IDLE); end
    nchecks++;
    if (dut.m1.wr_addr !== m_wr) begin nerr++; $display("FAIL rst_mid_wr_addr got=%h exp=%h", dut.m1.wr_addr, m_wr); end
    nchecks++;
    if (dut.cnt_q !== 4'd0) begin nerr++; $display("FAIL rst_mid_cnt got=%0d exp=0", dut.cnt_q); end
    nchecks++;
    @(negedge clk); rst = 1'b0; bus.SS_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_written[i] = 1'b0;
    test_reset();
    test_wr_addr();
    test_wr_data();
    test_rd_addr();
    test_rd_data();
    test_abort();
    test_random();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
